// File: rtl/pc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pc_sequencer                                                    |
// | Purpose  : Fetch-stage controller for a 5-stage RISC-V pipeline. Chooses   |
// |            the next PC from the boot vector, the trap vector, a branch     |
// |            redirect or PC+4. It weighs that choice against load-use        |
// |            hazards and a multi-cycle instruction-memory handshake. It also |
// |            drives the IF/ID and ID/EX stall/flush controls and runs a      |
// |            fetch-timeout watchdog.                                         |
// | Ports    : clk, rst (sync, active-low)                                     |
// |            pc in / next_pc, pc_write out         - PC register control    |
// |            imem_req out / imem_ready in          - fetch handshake         |
// |            id_ex_mem_read, id_ex_rd, if_id_rs1/2 - load-use detection      |
// |            branch_taken, branch_target           - EX redirect             |
// |            trap_req, trap_pc                     - trap entry              |
// |            if_id_write, if_id_flush, id_ex_flush - pipeline control        |
// |            fetch_fault, epc                      - watchdog / exception PC |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned IMEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic [31:0] next_pc,
  output logic        pc_write,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic        id_ex_mem_read,
  input  logic [4:0]  id_ex_rd,
  input  logic [4:0]  if_id_rs1,
  input  logic [4:0]  if_id_rs2,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        trap_req,
  input  logic [31:0] trap_pc,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        fetch_fault,
  output logic [31:0] epc
);

  // A zero timeout would give a zero-width counter; keep at least one bit.
  localparam int unsigned      c_CNT_W   = (IMEM_TIMEOUT > 0) ? $clog2(IMEM_TIMEOUT + 1) : 1;
  localparam bit               c_WD_EN   = (IMEM_TIMEOUT != 0);
  localparam logic [c_CNT_W-1:0] c_WD_LAST = c_CNT_W'(IMEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_TRAP  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               pend_q, pend_d;
  logic [31:0]        pend_tgt_q, pend_tgt_d;
  logic [c_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]        epc_q, epc_d;

  logic w_hazard;
  logic w_wd_expire;

  assign w_hazard = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                    ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));

  assign epc = epc_q;

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    pend_tgt_d  = pend_tgt_q;
    wait_cnt_d  = wait_cnt_q;
    epc_d       = epc_q;
    w_wd_expire = 1'b0;

    pc_write    = 1'b0;
    next_pc     = pc + 32'd4;
    imem_req    = 1'b0;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    fetch_fault = 1'b0;

    case (state_q)
      ST_BOOT: begin
        pc_write    = 1'b1;
        next_pc     = RESET_VECTOR;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        wait_cnt_d  = '0;
        state_d     = ST_FETCH;
      end

      // The request is dropped for one cycle so any outstanding fetch is
      // abandoned before the handler fetch starts.
      ST_TRAP: begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        wait_cnt_d  = '0;
        state_d     = ST_FETCH;
      end

      default: begin  // ST_FETCH and ST_WAIT behave identically
        imem_req    = 1'b1;
        wait_cnt_d  = imem_ready ? '0 : wait_cnt_q + c_CNT_W'(1);
        w_wd_expire = c_WD_EN && !imem_ready && (wait_cnt_q == c_WD_LAST);

        if (trap_req || w_wd_expire) begin
          pc_write    = 1'b1;
          next_pc     = TRAP_VECTOR;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          fetch_fault = !trap_req;
          epc_d       = trap_req ? trap_pc : pc;
          pend_d      = 1'b0;
          wait_cnt_d  = '0;
          state_d     = ST_TRAP;
        end else if (branch_taken && imem_ready) begin
          pc_write    = 1'b1;
          next_pc     = branch_target;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          state_d     = ST_FETCH;
        end else if (branch_taken) begin
          // Memory is still busy with pc; remember where to go once it answers.
          pend_d      = 1'b1;
          pend_tgt_d  = branch_target;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          state_d     = ST_WAIT;
        end else if (imem_ready && pend_q) begin
          // The word just returned belongs to the squashed path.
          pc_write    = 1'b1;
          next_pc     = pend_tgt_q;
          if_id_flush = 1'b1;
          pend_d      = 1'b0;
          state_d     = ST_FETCH;
        end else if (w_hazard) begin
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
          state_d     = imem_ready ? ST_FETCH : ST_WAIT;
        end else if (!imem_ready) begin
          if_id_flush = 1'b1;
          state_d     = ST_WAIT;
        end else begin
          pc_write    = 1'b1;
          state_d     = ST_FETCH;
        end
      end
    endcase

    if (!rst) begin
      pc_write    = 1'b0;
      next_pc     = RESET_VECTOR;
      imem_req    = 1'b0;
      if_id_write = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      fetch_fault = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_BOOT;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
      wait_cnt_q <= '0;
      epc_q      <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
      wait_cnt_q <= wait_cnt_d;
      epc_q      <= epc_d;
    end
  end

endmodule
`default_nettype wire
